out_port_fifo: RTL and testbench
================================

OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 Parameter WIDTH, default 16, data word width; matches processor datapath.
REQ-002 Parameter DEPTH, default 4, entries; power of two, 2..16.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 write_out  input  WIDTH  processor output-port data.
REQ-006 wr_en  input  1  push strobe, asserted for one cycle per processor output-port store.
REQ-007 dout  output  WIDTH  head-of-queue word to external consumer.
REQ-008 dout_valid  output  1  head word present.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky dropped-write flag.
REQ-014 ovf_clr  input  1  clears overflow.

Function
REQ-015 Push = wr_en && (!full || pop); pop = dout_valid && dout_ready.
REQ-016 Pushed word is written at the write pointer on the posedge where push is true; earliest dout_valid is the next cycle (1-cycle latency, no same-cycle bypass).
REQ-017 dout SHALL be the word at the read pointer, driven from storage; dout is don't-care while dout_valid is 0 but SHALL not be X after reset.
REQ-018 dout_valid SHALL equal !empty.
REQ-019 Pointers are $clog2(DEPTH) bits, increment by 1 per push/pop, wrap DEPTH-1 -> 0.
REQ-020 count: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-021 Full with simultaneous wr_en and pop: both occur, count stays DEPTH, no overflow.
REQ-022 Full with wr_en and no pop: write dropped, storage/pointers/count unchanged.
REQ-023 Empty with wr_en and dout_ready: push only (pop impossible since dout_valid=0); count becomes 1.
REQ-024 dout_ready while empty SHALL have no effect.
REQ-025 Order preserved: words leave in push order.

Reset
REQ-026 rst low SHALL asynchronously clear read/write pointers and count to 0, and overflow to 0; empty=1, full=0, dout_valid=0.
REQ-027 Storage contents SHALL be reset to 0 so dout=0 after reset.
REQ-028 Reset mid-operation discards all queued words; first post-reset push lands at entry 0.
REQ-029 rst release is synchronous-safe: no push/pop is taken on the cycle rst deasserts if rst is still low at that posedge.

Configuration
REQ-030 Macro OUT_PORT_FIFO_OVF_EN, when defined, enables overflow: set on the posedge of any dropped write (REQ-022), held until ovf_clr is high at a posedge; set has priority over simultaneous clear.
REQ-031 Without OUT_PORT_FIFO_OVF_EN, overflow SHALL be constant 0 and ovf_clr ignored; port list unchanged.

Structure
REQ-032 Shared package out_port_pkg SHALL hold WORD_W=16, OUT_FIFO_DEPTH=4, and the count/pointer width constants derived from them.
REQ-033 Storage SHALL be a separate sub-module out_port_fifo_ram (DEPTH x WIDTH, one write port, asynchronous read); pointer/count/flag control stays in out_port_fifo.

Verification
REQ-034 Reset: rst=0 mid-run with 3 words queued -> count=0, empty=1, dout_valid=0, dout=0 immediately, before next clock edge.
REQ-035 Latency/order: push 0x1111,0x2222,0x3333 with dout_ready=0, then dout_ready=1 -> dout_valid rises cycle after first push; dout sequence 0x1111,0x2222,0x3333; empty after third pop.
REQ-036 Full/drop: push 0xA000..0xA004 (5 words, DEPTH=4, no pops) -> full=1 after 4th, 5th dropped, count=4, overflow=1 (macro on) / 0 (macro off); drain yields 0xA000..0xA003.
REQ-037 Full simultaneous: at full, wr_en=1 with 0xBEEF and dout_ready=1 -> count stays 4, overflow stays 0, 0xBEEF emerges as 4th word after the three remaining.
REQ-038 Wrap-around: 10 push/pop pairs of 0x0001..0x000A interleaved at count 1..2 -> pointers wrap twice, output order exact, no flag asserted.
REQ-039 Overflow clear: overflow=1, pulse ovf_clr -> 0 next cycle; ovf_clr coincident with dropped write -> overflow stays 1.

Source files
------------

// File: rtl/out_port_pkg.sv
// rtl/out_port_pkg.sv - shared widths and depth for the processor output-port FIFO
package out_port_pkg;
  localparam int WORD_W         = 16;
  localparam int OUT_FIFO_DEPTH = 4;
  localparam int OUT_FIFO_PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int OUT_FIFO_CNT_W = OUT_FIFO_PTR_W + 1;
endpackage

// File: rtl/out_port_fifo_ram.sv
// rtl/out_port_fifo_ram.sv - DEPTH x WIDTH storage, one write port, asynchronous read
// Ports:
//   clock, rst   : clock and asynchronous active-low reset (clears every entry)
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : combinational read port
module out_port_fifo_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Entries are cleared so the head word reads as 0, never X, after reset.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - output-port FIFO between processor stores and an external consumer
// Ports:
//   clock, rst        : clock and asynchronous active-low reset
//   write_out, wr_en  : processor store data and one-cycle push strobe
//   dout, dout_valid  : head-of-queue word and its presence
//   dout_ready        : consumer accepts dout this cycle
//   full, empty, count: occupancy status
//   overflow, ovf_clr : sticky dropped-write flag and its clear
// Build option: OUT_PORT_FIFO_OVF_EN enables the overflow flag; otherwise it is
// tied to 0 and ovf_clr is ignored.
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         write_out,
  input  logic                     wr_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  assign empty      = (r_count == '0);
  assign full       = (r_count == CNT_W'(DEPTH));
  assign dout_valid = !empty;
  assign count      = r_count;

  // A pop frees the slot the push needs, so a full queue still accepts a word
  // when the consumer takes one in the same cycle.
  assign w_pop  = dout_valid && dout_ready;
  assign w_push = wr_en && (!full || w_pop);
  assign w_drop = wr_en && full && !w_pop;

  // DEPTH is a power of two, so natural pointer overflow gives the wrap.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  out_port_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clock (clock),
    .rst   (rst),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (write_out),
    .raddr (r_rd_ptr),
    .rdata (dout)
  );

`ifdef OUT_PORT_FIFO_OVF_EN
  logic r_overflow;

  // Setting wins over a coincident clear so no dropped write goes unreported.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
  // ovf_clr is masked to keep the port list identical across builds.
  assign overflow = ovf_clr & w_drop_unused & 1'b0;
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// tb/tb_out_port_fifo.sv - randomized and directed bench for out_port_fifo against a queue model
module tb_out_port_fifo;

  localparam int W = 16;
  localparam int D = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic [W-1:0]  write_out;
  logic          wr_en;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          full;
  logic          empty;
  logic [2:0]    count;
  logic          overflow;
  logic          ovf_clr;

  out_port_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .rst        (rst),
    .write_out  (write_out),
    .wr_en      (wr_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] model_q [$];
  bit           model_ovf = 1'b0;

`ifdef OUT_PORT_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(full), 32'(model_q.size() == D));
    check({tag, ".valid"}, 32'(dout_valid), 32'(model_q.size() != 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(model_ovf));
    if (model_q.size() != 0) check({tag, ".dout"}, 32'(dout), 32'(model_q[0]));
  endtask

  // One clock: drive inputs at negedge, check the pre-edge state, advance the model.
  task automatic step(input string tag, input bit we, input logic [W-1:0] data,
                      input bit rdy, input bit clr);
    bit is_full, do_pop, do_push, drop;
    @(negedge clock);
    wr_en = we; write_out = data; dout_ready = rdy; ovf_clr = clr;
    check_state(tag);
    is_full = (model_q.size() == D);
    do_pop  = (model_q.size() != 0) && rdy;
    do_push = we && (!is_full || do_pop);
    drop    = we && is_full && !do_pop;
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(data);
    if (OVF_EN && drop) model_ovf = 1'b1;
    else if (clr)       model_ovf = 1'b0;
    @(posedge clock);
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (model_q.size() != 0 && guard < 2 * D) begin
      step(tag, 1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; write_out = '0; dout_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.full", 32'(full), 0);
    check("rst.valid", 32'(dout_valid), 0);
    check("rst.dout", 32'(dout), 0);
    check("rst.ovf", 32'(overflow), 0);
    @(negedge clock);
    rst = 1'b1;

    // Latency and order
    step("lat", 1'b1, 16'h1111, 1'b0, 1'b0);
    step("lat", 1'b1, 16'h2222, 1'b0, 1'b0);
    step("lat", 1'b1, 16'h3333, 1'b0, 1'b0);
    repeat (3) step("lat", 1'b0, '0, 1'b1, 1'b0);
    step("lat.end", 1'b0, '0, 1'b1, 1'b0);

    // Full and dropped write
    for (int i = 0; i < 5; i++) step("full", 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    step("full.hold", 1'b0, '0, 1'b0, 1'b0);
    drain("full.drain");
    step("full.clr", 1'b0, '0, 1'b0, 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step("sim", 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
    step("sim.both", 1'b1, 16'hBEEF, 1'b1, 1'b0);
    drain("sim.drain");

    // Overflow clear, and clear coincident with a drop
    for (int i = 0; i < 4; i++) step("ovc", 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
    step("ovc.drop", 1'b1, 16'hDEAD, 1'b0, 1'b0);
    step("ovc.clr", 1'b0, '0, 1'b0, 1'b1);
    step("ovc.drclr", 1'b1, 16'hDEAF, 1'b0, 1'b1);
    step("ovc.chk", 1'b0, '0, 1'b0, 1'b0);
    drain("ovc.drain");
    step("ovc.clr2", 1'b0, '0, 1'b0, 1'b1);

    // Wrap-around at occupancy 1..2
    step("wrap", 1'b1, 16'h0001, 1'b0, 1'b0);
    for (int k = 2; k <= 10; k++) step("wrap", 1'b1, 16'(k), 1'b1, 1'b0);
    drain("wrap.drain");
    step("wrap.end", 1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 2) != 0), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    drain("rnd.drain");
    step("rnd.clr", 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset with three words queued
    for (int i = 0; i < 3; i++) step("arst", 1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.empty", 32'(empty), 1);
    check("arst.valid", 32'(dout_valid), 0);
    check("arst.dout", 32'(dout), 0);
    model_q.delete();
    model_ovf = 1'b0;
    wr_en = 1'b1; write_out = 16'hFFFF; dout_ready = 1'b1;
    @(posedge clock);
    #1;
    check("arst.held", 32'(count), 0);
    @(negedge clock);
    rst = 1'b1; wr_en = 1'b0;
    step("post", 1'b1, 16'h5A5A, 1'b0, 1'b0);
    step("post", 1'b0, '0, 1'b1, 1'b0);
    step("post.end", 1'b0, '0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
